// File: rtl/dmem_pkg.sv
// Shared types for the dmem_bank data memory: controller states, the response
// record carried down the read pipeline, and sizing helpers.
package dmem_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Sizing for the default 32-bit x 1024-word configuration; instances derive
  // their own values from DATA_W/DEPTH with cnt_width().
  localparam int DATA_W_DFLT = 32;
  localparam int DEPTH_DFLT  = 1024;
  localparam int BE_W        = DATA_W_DFLT / 8;
  localparam int CNT_W       = $clog2(DEPTH_DFLT);

  // Widest supported word; narrower instances use the low DATA_W bits.
  localparam int RSP_MAX_W = 256;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [RSP_MAX_W-1:0] rdata;
  } rsp_t;

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Delay line for memory responses: STAGES registers of rsp_t behind stage 0,
// flushed synchronously while rst_n is low.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  rsp_t rsp_in,
  output rsp_t rsp_out
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign rsp_out    = rsp_in;
    end else begin : g_pipe
      rsp_t rsp_pn [STAGES];

      // Stages 1..STAGES: plain shift, valid travels inside the record
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) begin
            rsp_pn[i] <= '0;
          end
        end else begin
          rsp_pn[0] <= rsp_in;
          for (int i = 1; i < STAGES; i++) begin
            rsp_pn[i] <= rsp_pn[i-1];
          end
        end
      end

      assign rsp_out = rsp_pn[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dmem_bank.sv
// Single-port word-addressed data memory with byte-enable writes, a registered
// read path of READ_LAT cycles, range error reporting and a post-reset clear.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CW     = cnt_width(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  // Kept as a plain array so benches can preload and inspect it by hierarchical name.
  reg [DATA_W-1:0] mem [0:DEPTH-1];

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] clr_cnt;
  logic          live;
  logic          acc;
  logic          in_range;
  logic [CW-1:0] idx;

  logic              vld_p0;
  logic              err_p0;
  logic [DATA_W-1:0] rdata_p0;
  rsp_t              rsp_p0;
  rsp_t              rsp_out;
  logic              unused_rsp;

  // Upper address bits are deliberately not masked: any of them set is an error.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return (64'(a) < 64'(DEPTH));
  endfunction

  assign in_range = addr_in_range(req_addr);
  assign idx      = req_addr[CW-1:0];
  assign acc      = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
      live    <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + CW'(1);
      end
    end
  end

  // live holds req_ready low for the first edge out of reset when no clear runs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    if (state == ST_CLEAR) begin
      busy = 1'b1;
      if (clr_cnt == LAST_IDX) begin
        state_nxt = ST_RUN;
      end
    end else begin
      req_ready = live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (acc && req_wen && in_range) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (req_be[b]) begin
            mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Stage 0: array read and range check at the acceptance edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      err_p0   <= 1'b0;
      rdata_p0 <= '0;
    end else begin
      vld_p0   <= acc;
      err_p0   <= acc & ~in_range;
      rdata_p0 <= (acc && !req_wen && in_range) ? mem[idx] : '0;
    end
  end

  always_comb begin
    rsp_p0                    = '0;
    rsp_p0.valid              = vld_p0;
    rsp_p0.err                = err_p0;
    rsp_p0.rdata[DATA_W-1:0]  = rdata_p0;
  end

  // Stages 1..READ_LAT-1: response delay line
  dmem_rsp_pipe #(
    .STAGES (READ_LAT - 1)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .rsp_in  (rsp_p0),
    .rsp_out (rsp_out)
  );

  assign rsp_valid  = rsp_out.valid;
  assign rsp_err    = rsp_out.err;
  assign rsp_rdata  = rsp_out.rdata[DATA_W-1:0];
  assign unused_rsp = ^rsp_out.rdata;

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: three configurations driven with directed and random
// traffic, every cycle compared against a transaction-level memory model.
`timescale 1ns/1ps
module tb_dmem_bank;

  localparam int NI = 3;

  function automatic int depth_of(input int k);
    case (k)
      0:       return 16;
      1:       return 1024;
      default: return 40;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit clr_of(input int k);
    return (k == 0);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_wen   [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic        rsp_err   [NI];
  logic [31:0] rsp_rdata [NI];
  logic        busy      [NI];

  always #5 clk = ~clk;

  dmem_bank #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_bank #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .READ_LAT(3), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  dmem_bank #(.DATA_W(32), .DEPTH(40), .ADDR_W(32), .READ_LAT(4), .CLEAR_ON_RESET(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

  // Reference model: word contents, edges left before ready, pending responses.
  typedef struct {
    int          k;
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic [31:0] mref [NI][1024];
  int          rdy_cnt [NI];
  exp_t        q [$];
  int          cyc;
  int          checks;
  int          failures;

  task automatic drive(input int k, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid[k] = v;
    req_wen[k]   = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One clock: advance the model for every instance, return observed and
  // predicted {req_ready, busy, rsp_valid, rsp_err, rsp_rdata} for instance k.
  task automatic tick(input int k, output logic [35:0] obsv, output logic [35:0] expv);
    bit          acc [NI];
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    int          i;
    for (int j = 0; j < NI; j++) begin
      acc[j] = rst_n[j] && req_valid[j] && (rdy_cnt[j] == 0);
    end
    @(posedge clk);
    cyc++;
    for (int j = 0; j < NI; j++) begin
      if (!rst_n[j]) begin
        for (int n = q.size() - 1; n >= 0; n--) begin
          if (q[n].k == j) q.delete(n);
        end
        rdy_cnt[j] = clr_of(j) ? depth_of(j) : 1;
        if (clr_of(j)) begin
          for (int a = 0; a < depth_of(j); a++) mref[j][a] = 32'h0;
        end
      end else begin
        if (acc[j]) begin
          exp_t e;
          e.k    = j;
          e.due  = cyc + lat_of(j) - 1;
          e.err  = (req_addr[j] >= 32'(depth_of(j)));
          e.data = 32'h0;
          if (!e.err) begin
            if (req_wen[j]) begin
              for (int b = 0; b < 4; b++) begin
                if (req_be[j][b]) mref[j][req_addr[j]][8*b +: 8] = req_wdata[j][8*b +: 8];
              end
            end else begin
              e.data = mref[j][req_addr[j]];
            end
          end
          q.push_back(e);
        end
        if (rdy_cnt[j] > 0) rdy_cnt[j]--;
      end
    end
    @(negedge clk);
    ev = 1'b0;
    ee = 1'b0;
    ed = 32'h0;
    i  = 0;
    while (i < q.size()) begin
      if (q[i].due == cyc) begin
        if (q[i].k == k) begin
          ev = 1'b1;
          ee = q[i].err;
          ed = q[i].data;
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
    expv = {rdy_cnt[k] == 0, clr_of(k) && (rdy_cnt[k] != 0), ev, ee, ed};
    obsv = {req_ready[k], busy[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]};
  endtask

  task automatic test_reset();
    logic [35:0] o, e;
    int first_rdy;
    for (int j = 0; j < NI; j++) begin
      rst_n[j] = 1'b0;
      idle(j);
    end
    repeat (2) begin
      tick(0, o, e);
      checks++;
      if (o !== e || o !== 36'h4_0000_0000) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    for (int j = 0; j < NI; j++) rst_n[j] = 1'b1;
    first_rdy = -1;
    for (int t = 1; t <= 20; t++) begin
      tick(0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[35] === 1'b1 && first_rdy < 0) first_rdy = t;
    end
    checks++;
    if (first_rdy != 16) begin
      failures++;
      $display("FAIL clear_duration got=%0d want=16", first_rdy);
    end
  endtask

  task automatic test_clear_readback();
    logic [35:0] o, e;
    int seen;
    seen = 0;
    for (int t = 0; t < 18; t++) begin
      if (t < 16) drive(0, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      else idle(0);
      tick(0, o, e);
      checks++;
      if (o !== e || (o[33] && o[31:0] !== 32'h0)) begin
        failures++;
        $display("FAIL clear_readback cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[33]) seen++;
    end
    checks++;
    if (seen != 16) begin
      failures++;
      $display("FAIL clear_readback_count got=%0d want=16", seen);
    end
  endtask

  task automatic test_byte_enable();
    logic [35:0] o, e;
    drive(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'b1111);
    tick(0, o, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL be_write_full got=%h want=%h", o, e);
    end
    drive(0, 1'b1, 1'b1, 32'd5, 32'h000000AA, 4'b0001);
    tick(0, o, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL be_write_byte got=%h want=%h", o, e);
    end
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
    tick(0, o, e);
    checks++;
    if (o !== e || o[33:0] !== {2'b10, 32'hDEADBEAA}) begin
      failures++;
      $display("FAIL be_read got=%h want=%h", o, e);
    end
    idle(0);
    tick(0, o, e);
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL be_idle got=%h want=%h", o, e);
    end
  endtask

  task automatic test_reset_restart();
    logic [35:0] o, e;
    int first_rdy;
    for (int t = 0; t < 4; t++) begin
      drive(0, 1'b1, 1'b1, 32'(t + 2), $urandom, 4'hF);
      tick(0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart_write cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    idle(0);
    rst_n[0] = 1'b0;
    tick(0, o, e);
    rst_n[0] = 1'b1;
    repeat (5) tick(0, o, e);
    rst_n[0] = 1'b0;
    tick(0, o, e);
    rst_n[0] = 1'b1;
    first_rdy = -1;
    for (int t = 1; t <= 20; t++) begin
      tick(0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart_clear cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[35] === 1'b1 && first_rdy < 0) first_rdy = t;
    end
    checks++;
    if (first_rdy != 16) begin
      failures++;
      $display("FAIL restart_duration got=%0d want=16", first_rdy);
    end
    for (int t = 0; t < 17; t++) begin
      if (t < 16) drive(0, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      else idle(0);
      tick(0, o, e);
      checks++;
      if (o !== e || (o[33] && o[31:0] !== 32'h0)) begin
        failures++;
        $display("FAIL restart_readback cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
  endtask

  task automatic test_fill(input int k);
    logic [35:0] o, e;
    for (int t = 0; t < depth_of(k) + lat_of(k); t++) begin
      if (t < depth_of(k)) drive(k, 1'b1, 1'b1, 32'(t), (k == 1) ? 32'(t) : $urandom, 4'hF);
      else idle(k);
      tick(k, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL fill k=%0d cyc=%0d got=%h want=%h", k, cyc, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] o, e;
    int seen, first_t;
    seen    = 0;
    first_t = -1;
    for (int t = 0; t < 12; t++) begin
      if (t < 8) drive(1, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      else idle(1);
      tick(1, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[33]) begin
        if (first_t < 0) first_t = t;
        checks++;
        if (o[31:0] !== 32'(seen) || t != first_t + seen) begin
          failures++;
          $display("FAIL b2b_order t=%0d got=%h want=%h", t, o[31:0], seen);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 8 || first_t != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d/%0d want=8/2", seen, first_t);
    end
  endtask

  task automatic test_raw();
    logic [35:0] o, e;
    logic [31:0] got;
    got = 32'h0;
    for (int t = 0; t < 6; t++) begin
      if (t == 0) drive(1, 1'b1, 1'b1, 32'd9, 32'h12345678, 4'hF);
      else if (t == 1) drive(1, 1'b1, 1'b0, 32'd9, 32'h0, 4'h0);
      else idle(1);
      tick(1, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL raw cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (t == 3) got = o[31:0];
    end
    checks++;
    if (got !== 32'h12345678) begin
      failures++;
      $display("FAIL raw_data got=%h want=12345678", got);
    end
  endtask

  task automatic test_out_of_range();
    logic [35:0] o, e;
    logic [3:0]  errs;
    logic [31:0] adr [4];
    int seen;
    adr[0] = 32'd1024;
    adr[1] = 32'd2000;
    adr[2] = 32'h8000_0005;
    adr[3] = 32'd3;
    errs   = 4'h0;
    seen   = 0;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) drive(1, 1'b1, (t == 1), adr[t], 32'hFFFFFFFF, 4'hF);
      else idle(1);
      tick(1, o, e);
      checks++;
      if (o !== e || (o[32] && o[31:0] !== 32'h0)) begin
        failures++;
        $display("FAIL oor cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[33] && seen < 4) begin
        errs[seen] = o[32];
        seen++;
      end
    end
    checks++;
    if (errs !== 4'b0111 || seen != 4) begin
      failures++;
      $display("FAIL oor_errs got=%b want=0111", errs);
    end
    for (int t = 0; t < 1024 + 3; t++) begin
      if (t < 1024) drive(1, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      else idle(1);
      tick(1, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL array_compare cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [35:0] o, e;
    logic [31:0] a;
    for (int t = 0; t < n + lat_of(k); t++) begin
      if (t < n) begin
        a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, depth_of(k) + 3));
        drive(k, ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, a, $urandom,
              4'($urandom_range(0, 15)));
      end else begin
        idle(k);
      end
      tick(k, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random k=%0d cyc=%0d got=%h want=%h", k, cyc, o, e);
      end
    end
  endtask

  task automatic test_reset_flight();
    logic [35:0] o, e;
    int stray;
    stray = 0;
    for (int t = 0; t < 3; t++) begin
      drive(2, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      tick(2, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL flight_issue cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
    idle(2);
    rst_n[2] = 1'b0;
    tick(2, o, e);
    rst_n[2] = 1'b1;
    checks++;
    if (o !== e || o !== 36'h0) begin
      failures++;
      $display("FAIL flight_reset got=%h want=%h", o, e);
    end
    for (int t = 0; t < 8; t++) begin
      tick(2, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL flight_drop cyc=%0d got=%h want=%h", cyc, o, e);
      end
      if (o[33] !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL flight_stray got=%0d want=0", stray);
    end
    for (int t = 0; t < 40 + 4; t++) begin
      if (t < 40) drive(2, 1'b1, 1'b0, 32'(t), 32'h0, 4'h0);
      else idle(2);
      tick(2, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL flight_intact cyc=%0d got=%h want=%h", cyc, o, e);
      end
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    for (int j = 0; j < NI; j++) begin
      rst_n[j]   = 1'b0;
      rdy_cnt[j] = 1;
      idle(j);
    end
    test_reset();
    test_clear_readback();
    test_byte_enable();
    test_reset_restart();
    test_fill(1);
    test_fill(2);
    test_back_to_back();
    test_raw();
    test_out_of_range();
    test_random(0, 300);
    test_random(2, 300);
    test_random(1, 200);
    test_reset_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
